// File: rtl/mmio_i2c_core.sv
// rtl/mmio_i2c_core.sv - byte-level I2C master behind one MMIO register slot
//
// Purpose: software writes a bit-rate divisor and byte commands (START, WR, RD,
// STOP, RESTART). The core sequences open-drain SCL/SDA, one quarter-bit phase
// per FSM state, and reports the received byte and ACK bit in a status register.
//
// Ports:
//   clk      - system clock
//   reset    - asynchronous active-high reset
//   cs       - slot chip select
//   read     - read strobe (the read mux is combinational, so it is not needed)
//   write    - write strobe, qualified by cs
//   addr     - register index, only addr[1:0] decoded
//   wr_data  - write data
//   rd_data  - combinational read data
//   i2c_scl  - SCL, drives 0 or high-Z
//   i2c_sda  - SDA, drives 0 or high-Z, sampled while released
module mmio_i2c_core #(
  parameter int ADDR_WIDTH = 5,
  parameter int DVSR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  output wire                   i2c_scl,
  inout  wire                   i2c_sda
);

  typedef enum logic [3:0] {
    S_IDLE, S_START1, S_START2, S_HOLD,
    S_DATA1, S_DATA2, S_DATA3, S_DATA4, S_DATA_END,
    S_RESTART1, S_RESTART2, S_STOP1, S_STOP2
  } state_t;

  localparam logic [2:0] CMD_START   = 3'd0;
  localparam logic [2:0] CMD_WR      = 3'd1;
  localparam logic [2:0] CMD_RD      = 3'd2;
  localparam logic [2:0] CMD_STOP    = 3'd3;
  localparam logic [2:0] CMD_RESTART = 3'd4;

  localparam logic [DVSR_WIDTH-1:0] CNT_ONE = 1;

  state_t                  state_q, state_d;
  logic [DVSR_WIDTH-1:0]   dvsr_q;
  logic [DVSR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic [8:0]              tx_q, tx_d;
  logic [8:0]              rx_q, rx_d;
  logic [8:0]              stat_q, stat_d;

  logic       ready;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [7:0] din;
  logic       phase_done;
  logic       scl_rel, sda_rel;
  logic       sda_in;
  logic       unused_inputs;

  assign unused_inputs = ^{read, addr, wr_data};

  assign ready      = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign cmd        = wr_data[10:8];
  assign din        = wr_data[7:0];
  assign cmd_valid  = cs && write && (addr[1:0] == 2'd2) && ready;
  assign phase_done = (cnt_q == dvsr_q);
  assign sda_in     = i2c_sda;

  // A '1' is never driven: release the line and let the pull-up do it.
  assign i2c_scl = scl_rel ? 1'bz : 1'b0;
  assign i2c_sda = sda_rel ? 1'bz : 1'b0;

  always_comb begin
    rd_data = '0;
    if (addr[1:0] == 2'd0) begin
      rd_data = {22'b0, stat_q[0], ready, stat_q[8:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvsr_q <= '0;
    end else if (cs && write && (addr[1:0] == 2'd1)) begin
      dvsr_q <= wr_data[DVSR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      stat_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      stat_q    <= stat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    stat_d    = stat_q;
    scl_rel   = 1'b1;
    sda_rel   = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && (cmd == CMD_START)) state_d = S_START1;
      end
      S_START1: begin
        sda_rel = 1'b0;
        if (phase_done) state_d = S_START2;
      end
      S_START2: begin
        scl_rel = 1'b0;
        sda_rel = 1'b0;
        if (phase_done) state_d = S_HOLD;
      end
      S_HOLD: begin
        scl_rel = 1'b0;
        sda_rel = 1'b0;
        if (cmd_valid) begin
          case (cmd)
            CMD_WR: begin
              tx_d      = {din, 1'b1};
              bit_cnt_d = '0;
              state_d   = S_DATA1;
            end
            CMD_RD: begin
              tx_d      = {8'hFF, din[0]};
              bit_cnt_d = '0;
              state_d   = S_DATA1;
            end
            CMD_STOP:    state_d = S_STOP1;
            CMD_RESTART: state_d = S_RESTART1;
            default:     state_d = S_HOLD;
          endcase
        end
      end
      S_DATA1: begin
        scl_rel = 1'b0;
        sda_rel = tx_q[8];
        if (phase_done) state_d = S_DATA2;
      end
      S_DATA2: begin
        sda_rel = tx_q[8];
        if (phase_done) begin
          // Sample mid-way through the SCL high time.
          rx_d    = {rx_q[7:0], sda_in};
          state_d = S_DATA3;
        end
      end
      S_DATA3: begin
        sda_rel = tx_q[8];
        if (phase_done) state_d = S_DATA4;
      end
      S_DATA4: begin
        scl_rel = 1'b0;
        sda_rel = tx_q[8];
        if (phase_done) begin
          if (bit_cnt_q == 4'd8) begin
            state_d = S_DATA_END;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_d      = {tx_q[7:0], 1'b0};
            state_d   = S_DATA1;
          end
        end
      end
      S_DATA_END: begin
        scl_rel = 1'b0;
        sda_rel = 1'b0;
        if (phase_done) begin
          // Status only changes once a whole byte is done, so software sees
          // a stable result in HOLD.
          stat_d  = rx_q;
          state_d = S_HOLD;
        end
      end
      S_RESTART1: begin
        scl_rel = 1'b0;
        if (phase_done) state_d = S_RESTART2;
      end
      S_RESTART2: begin
        if (phase_done) state_d = S_START1;
      end
      S_STOP1: begin
        sda_rel = 1'b0;
        if (phase_done) state_d = S_STOP2;
      end
      S_STOP2: begin
        if (phase_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Phase timer restarts on every state change and idles at 0 while waiting
  // for software.
  always_comb begin
    cnt_d = cnt_q + CNT_ONE;
    if ((state_d != state_q) || ready) cnt_d = '0;
  end

endmodule

// File: tb/tb_mmio_i2c_core.sv
// tb/tb_mmio_i2c_core.sv - self-checking bench for mmio_i2c_core
module tb_mmio_i2c_core;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cs = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wr_data = '0;
  logic [31:0]   rd_data;
  wire           scl_w;
  wire           sda_w;

  pullup (scl_w);
  pullup (sda_w);

  logic sl_low = 1'b0;
  bit   sl_q[$];
  assign sda_w = sl_low ? 1'b0 : 1'bz;

  mmio_i2c_core #(.ADDR_WIDTH(AW), .DVSR_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .i2c_scl(scl_w), .i2c_sda(sda_w)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Bus monitor and scripted slave: counts SCL rises, START/STOP conditions,
  // SCL high widths, captures SDA on each SCL rise, and advances the slave's
  // SDA script on each SCL fall.
  int   rises = 0, starts = 0, stops = 0;
  int   hi_run = 0, hi_min = 0, hi_max = 0;
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  bit   bits_q[$];

  initial forever begin
    @(negedge clk);
    #2;
    if (reset) begin
      prev_scl = 1'b1;
      prev_sda = 1'b1;
      hi_run   = 0;
    end else begin
      logic fell;
      fell = !scl_w && prev_scl;
      if (scl_w && !prev_scl) begin
        rises++;
        bits_q.push_back(sda_w);
      end
      if (scl_w && prev_scl && prev_sda && !sda_w) starts++;
      if (scl_w && prev_scl && !prev_sda && sda_w) stops++;
      if (scl_w) hi_run++;
      prev_scl = scl_w;
      prev_sda = sda_w;
      if (fell) begin
        if (hi_min == 0 || hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        hi_run = 0;
        if (sl_q.size() > 0) sl_low = !sl_q.pop_front();
        else sl_low = 1'b0;
      end
    end
  end

  task automatic load_slave(input logic [8:0] b);
    sl_q.delete();
    for (int i = 7; i >= 0; i--) sl_q.push_back(b[i]);
    sl_low = !b[8];
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = AW'(a); wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0; addr = '0;
  endtask

  task automatic read_status(output logic [31:0] v);
    addr = '0; cs = 1'b1; read = 1'b1;
    #1;
    v = rd_data;
    cs = 1'b0; read = 1'b0;
  endtask

  // Issues a command and counts the clocks ready stays low. With inject set,
  // a WR is written during the first busy cycle; it must be dropped.
  task automatic issue_cmd(input logic [2:0] c, input logic [7:0] d, input bit inject,
                           output int busy);
    bit done;
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = AW'(2); wr_data = {21'b0, c, d};
    @(negedge clk);
    cs = 1'b0; write = 1'b0; addr = '0;
    busy = 0;
    done = 1'b0;
    for (int g = 0; g < 4000; g++) begin
      #1;
      if (rd_data[8]) begin
        done = 1'b1;
        break;
      end
      busy++;
      if (inject && busy == 1) begin
        cs = 1'b1; write = 1'b1; addr = AW'(2); wr_data = {21'b0, 3'd1, 8'h5A};
      end
      @(negedge clk);
      cs = 1'b0; write = 1'b0; addr = '0;
    end
    check("ready_timeout", {31'b0, done}, 32'd1);
  endtask

  function automatic logic [8:0] bus_byte();
    logic [8:0] v;
    v = '0;
    if (bits_q.size() < 9) return 9'h0xx;
    for (int i = 0; i < 9; i++) v = {v[7:0], bits_q[i]};
    return v;
  endfunction

  typedef struct {
    bit         is_rd;
    logic [7:0] din;
    logic [7:0] sl_data;
    bit         sl_ack;
    logic [7:0] exp_rx;
    bit         exp_ack;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] st;
    int busy, r0, s0, p0;

    vecs[0] = '{1'b0, 8'hA5, 8'hFF, 1'b0, 8'hA5, 1'b0};
    vecs[1] = '{1'b0, 8'h3C, 8'hFF, 1'b1, 8'h3C, 1'b1};
    vecs[2] = '{1'b1, 8'h01, 8'h3C, 1'b1, 8'h3C, 1'b1};
    vecs[3] = '{1'b1, 8'h00, 8'hC3, 1'b1, 8'hC3, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 8'hFE, 8'hFF, 1'b1, 8'hFF, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_scl", {31'b0, scl_w}, 32'd1);
    check("rst_sda", {31'b0, sda_w}, 32'd1);
    check("rst_status", rd_data, 32'h0000_0100);
    reset = 1'b0;
    for (int a = 1; a < 4; a++) begin
      addr = AW'(a);
      #1;
      check($sformatf("rd_addr%0d", a), rd_data, 32'd0);
    end
    addr = '0;

    // START waveform with dvsr=4
    reg_write(2'd1, 32'd4);
    reg_write(2'd2, {21'b0, 3'd0, 8'h00});
    for (int k = 1; k <= 11; k++) begin
      logic [2:0] exp_w;
      #1;
      exp_w = (k <= 5) ? 3'b100 : (k <= 10) ? 3'b000 : 3'b001;
      check($sformatf("start_wave[%0d]", k), {29'b0, scl_w, sda_w, rd_data[8]}, {29'b0, exp_w});
      @(negedge clk);
    end

    // Byte table at dvsr=4
    for (int i = 0; i < 6; i++) begin
      load_slave(vecs[i].is_rd ? {vecs[i].sl_data, 1'b1} : {8'hFF, vecs[i].sl_ack});
      bits_q.delete();
      hi_min = 0; hi_max = 0;
      r0 = rises;
      issue_cmd(vecs[i].is_rd ? 3'd2 : 3'd1, vecs[i].din, 1'b0, busy);
      check($sformatf("byte%0d_busy", i), busy, 32'd185);
      check($sformatf("byte%0d_pulses", i), rises - r0, 32'd9);
      check($sformatf("byte%0d_bus", i), {23'b0, bus_byte()}, {23'b0, vecs[i].exp_rx, vecs[i].exp_ack});
      read_status(st);
      check($sformatf("byte%0d_status", i), st, {22'b0, vecs[i].exp_ack, 1'b1, vecs[i].exp_rx});
      check($sformatf("byte%0d_hi_min", i), hi_min, 32'd10);
      check($sformatf("byte%0d_hi_max", i), hi_max, 32'd10);
    end

    // RESTART from HOLD with a dropped busy-time WR
    r0 = rises; s0 = starts;
    issue_cmd(3'd4, 8'h00, 1'b1, busy);
    check("restart_busy", busy, 32'd20);
    repeat (20) @(negedge clk);
    #1;
    check("restart_starts", starts - s0, 32'd1);
    check("restart_rises", rises - r0, 32'd1);
    check("restart_ready", {31'b0, rd_data[8]}, 32'd1);

    // STOP, then WR while IDLE is ignored
    p0 = stops;
    issue_cmd(3'd3, 8'h00, 1'b0, busy);
    check("stop_busy", busy, 32'd10);
    check("stop_cond", stops - p0, 32'd1);
    r0 = rises;
    issue_cmd(3'd1, 8'h00, 1'b0, busy);
    repeat (10) @(negedge clk);
    #1;
    check("idle_wr_busy", busy, 32'd0);
    check("idle_wr_rises", rises - r0, 32'd0);
    check("idle_bus", {30'b0, scl_w, sda_w}, 32'd3);

    // Reset in DATA2 of a WR
    reg_write(2'd2, {21'b0, 3'd0, 8'h00});
    repeat (12) @(negedge clk);
    load_slave(9'h1FF);
    reg_write(2'd2, {21'b0, 3'd1, 8'h00});
    busy = 0;
    for (int g = 0; g < 200; g++) begin
      #1;
      if (scl_w) break;
      busy++;
      @(negedge clk);
    end
    check("pre_rst_sda_low", {31'b0, sda_w}, 32'd0);
    check("pre_rst_scl_high", {31'b0, scl_w}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_async_bus", {30'b0, scl_w, sda_w}, 32'd3);
    check("rst_async_status", rd_data, 32'h0000_0100);
    @(negedge clk);
    reset = 1'b0;
    sl_q.delete(); sl_low = 1'b0;
    issue_cmd(3'd0, 8'h00, 1'b0, busy);
    check("post_rst_start_busy", busy, 32'd2);
    issue_cmd(3'd3, 8'h00, 1'b0, busy);
    check("post_rst_stop_busy", busy, 32'd2);

    // Randomized command stream against a transaction-level model
    begin
      int   d, phases, e_rises, e_starts, e_stops;
      bit   open;
      logic [7:0] m_rx;
      logic m_ack;
      d = $urandom_range(0, 3);
      reg_write(2'd1, d);
      open = 1'b0; m_rx = 8'h00; m_ack = 1'b0;
      e_rises = 0; e_starts = 0; e_stops = 0;
      r0 = rises; s0 = starts; p0 = stops;
      for (int it = 0; it < 40; it++) begin
        logic [2:0] c;
        logic [7:0] dn, sd;
        logic [8:0] mst, slv, bus;
        bit sa, inj;
        c = 3'($urandom_range(0, 7));
        dn = 8'($urandom); sd = 8'($urandom);
        sa = 1'($urandom_range(0, 1)); inj = 1'($urandom_range(0, 1));
        phases = 0;
        if (!open) begin
          if (c == 3'd0) begin phases = 2; open = 1'b1; e_starts++; end
        end else if (c == 3'd1 || c == 3'd2) begin
          phases = 37;
          e_rises += 9;
          mst = (c == 3'd1) ? {dn, 1'b1} : {8'hFF, dn[0]};
          slv = (c == 3'd1) ? {8'hFF, sa} : {sd, 1'b1};
          bus = mst & slv;
          m_rx = bus[8:1]; m_ack = bus[0];
          load_slave(slv);
        end else if (c == 3'd3) begin
          phases = 2; open = 1'b0; e_stops++; e_rises++;
        end else if (c == 3'd4) begin
          phases = 4; e_starts++; e_rises++;
        end
        issue_cmd(c, dn, inj, busy);
        check($sformatf("rnd%0d_busy cmd%0d", it, c), busy, phases * (d + 1));
        read_status(st);
        check($sformatf("rnd%0d_status", it), st, {22'b0, m_ack, 1'b1, m_rx});
      end
      if (open) begin
        issue_cmd(3'd3, 8'h00, 1'b0, busy);
        e_stops++; e_rises++;
      end
      repeat (4) @(negedge clk);
      check("rnd_rises", rises - r0, e_rises);
      check("rnd_starts", starts - s0, e_starts);
      check("rnd_stops", stops - p0, e_stops);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
